sa_a_skew_feeder: RTL and testbench

//   Upstream feeder for the left edge of the NxN systolic PE array. Buffers A column-vectors
//   (one element per array row) from a valid/ready stream, then drives them onto the left-column
//   a_in ports with diagonal skew (row i delayed i advance-steps), plus the array-wide
//   en_shift_right and data_clear controls. Sequenced by a start/done handshake from the array controller.

---
 rtl/sa_a_skew_feeder.sv | 228 ++++++++++++++++++++++
 tb/tb_sa_a_skew_feeder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_a_skew_feeder.sv
// sa_a_skew_feeder
//   Feeds the left edge of an NxN systolic PE array. A column-vectors arrive on a
//   valid/ready stream and are buffered in a small FIFO. On an accepted start the block
//   does the following, in order:
//     - clears the array accumulators for one cycle;
//     - streams cfg_len vectors onto a_out with diagonal skew, so that row i lags row 0
//       by i advance steps;
//     - flushes the skew pipeline with N-1 zero vectors;
//     - pulses done.
//
// Ports
//   Clock, rst_n     clock (rising edge), asynchronous active-low reset
//   s_valid/s_ready  input vector handshake; s_data lane i = [i*DW +: DW] -> row i
//   start, cfg_len   burst request (IDLE only) and burst length in vectors
//   a_out            skewed A data, lane i drives row i a_in
//   en_shift_right   array A-shift enable, aligned with a_out
//   data_clear       array accumulator clear, aligned with a_out
//   busy, done       burst in progress / one-cycle end-of-burst pulse
//   fifo_count       vectors currently buffered
module sa_a_skew_feeder #(
    parameter int N     = 4,
    parameter int DW    = 16,
    parameter int DEPTH = 8
) (
    input  logic                         Clock,
    input  logic                         rst_n,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [N*DW-1:0]              s_data,
    input  logic                         start,
    input  logic [$clog2(DEPTH+1)-1:0]   cfg_len,
    output logic [N*DW-1:0]              a_out,
    output logic                         en_shift_right,
    output logic                         data_clear,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    logic [1:0]      state_reg;
    logic [CW-1:0]   remain_reg;
    logic [FW-1:0]   flush_reg;
    logic [CW-1:0]   count_reg;
    logic [CW-1:0]   count_next;
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic            s_ready_reg;
    logic            en_reg;
    logic            clear_reg;
    logic            done_reg;
    logic [N*DW-1:0] mem [DEPTH];
    logic [N*DW-1:0] rd_data;

    logic push;
    logic pop;
    logic advance;
    logic clear_cyc;
    logic start_ok;
    logic last_pop;
    logic burst_end;

    // s_ready is a register, so a push can never land on a full FIFO.
    assign push      = s_valid & s_ready_reg;
    assign pop       = (state_reg == S_RUN) && (count_reg != '0);
    assign advance   = pop || (state_reg == S_FLUSH);
    assign clear_cyc = (state_reg == S_CLEAR);
    assign start_ok  = (state_reg == S_IDLE) && start && (cfg_len != '0)
                       && (cfg_len <= CW'(DEPTH));
    assign last_pop  = pop && (remain_reg == CW'(1));
    // With a single row there is no skew to flush, so the burst ends on the last pop.
    assign burst_end = (last_pop && (N == 1))
                       || ((state_reg == S_FLUSH) && (flush_reg == FW'(1)));
    assign rd_data   = mem[rd_ptr_reg];

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (pop && !push) begin
            count_next = count_reg - 1'b1;
        end
    end

    // FIFO storage: write-only port; the read side is a plain array lookup.
    always_ff @(posedge Clock) begin
        if (push) begin
            mem[wr_ptr_reg] <= s_data;
        end
    end

    always_ff @(posedge Clock or negedge rst_n) begin
        if (!rst_n) begin
            count_reg   <= '0;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            s_ready_reg <= 1'b0;
        end else begin
            count_reg   <= count_next;
            s_ready_reg <= (count_next < CW'(DEPTH));
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // Burst sequencer.
    always_ff @(posedge Clock or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            remain_reg <= '0;
            flush_reg  <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start_ok) begin
                        state_reg  <= S_CLEAR;
                        remain_reg <= cfg_len;
                    end
                end
                S_CLEAR: begin
                    state_reg <= S_RUN;
                end
                S_RUN: begin
                    if (pop) begin
                        remain_reg <= remain_reg - 1'b1;
                        if (remain_reg == CW'(1)) begin
                            if (N == 1) begin
                                state_reg <= S_IDLE;
                            end else begin
                                state_reg <= S_FLUSH;
                                flush_reg <= FW'(N - 1);
                            end
                        end
                    end
                end
                S_FLUSH: begin
                    flush_reg <= flush_reg - 1'b1;
                    if (flush_reg == FW'(1)) begin
                        state_reg <= S_IDLE;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // Controls are registered in the same stage as a_out so the array sees them together.
    always_ff @(posedge Clock or negedge rst_n) begin
        if (!rst_n) begin
            en_reg    <= 1'b0;
            clear_reg <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            en_reg    <= advance;
            clear_reg <= clear_cyc;
            done_reg  <= burst_end;
        end
    end

    // Per-lane skew: lane i passes through i delay stages, then the shared output stage.
    // During flush nothing is popped, so zeros are injected.
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        logic [DW-1:0] lane_in;
        logic [DW-1:0] tap;
        logic [DW-1:0] out_q;

        assign lane_in = pop ? rd_data[gi*DW +: DW] : '0;

        if (gi == 0) begin : g_direct
            assign tap = lane_in;
        end else begin : g_delay
            logic [DW-1:0] line [gi];

            always_ff @(posedge Clock or negedge rst_n) begin
                if (!rst_n) begin
                    for (int j = 0; j < gi; j++) begin
                        line[j] <= '0;
                    end
                end else if (clear_cyc) begin
                    for (int j = 0; j < gi; j++) begin
                        line[j] <= '0;
                    end
                end else if (advance) begin
                    line[0] <= lane_in;
                    for (int j = 1; j < gi; j++) begin
                        line[j] <= line[j-1];
                    end
                end
            end

            assign tap = line[gi-1];
        end

        always_ff @(posedge Clock or negedge rst_n) begin
            if (!rst_n) begin
                out_q <= '0;
            end else if (clear_cyc) begin
                out_q <= '0;
            end else if (advance) begin
                out_q <= tap;
            end
        end

        assign a_out[gi*DW +: DW] = out_q;
    end

    assign s_ready        = s_ready_reg;
    assign en_shift_right = en_reg;
    assign data_clear     = clear_reg;
    assign done           = done_reg;
    assign busy           = (state_reg != S_IDLE);
    assign fifo_count     = count_reg;

endmodule

// File: tb/tb_sa_a_skew_feeder.sv
// tb_sa_a_skew_feeder
//   Directed sequence with random vector data for sa_a_skew_feeder (N=4, DW=16, DEPTH=8).
//   The reference keeps the FIFO contents as a queue. Expected a_out after advance m is
//   derived directly from the skew rule: lane i shows lane i of vector (m - i) when that
//   index lies inside the burst, and zero otherwise.
module tb_sa_a_skew_feeder;

    localparam int N     = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic            Clock = 1'b0;
    logic            rst_n;
    logic            s_valid;
    logic            s_ready;
    logic [N*DW-1:0] s_data;
    logic            start;
    logic [CW-1:0]   cfg_len;
    logic [N*DW-1:0] a_out;
    logic            en_shift_right;
    logic            data_clear;
    logic            busy;
    logic            done;
    logic [CW-1:0]   fifo_count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [N*DW-1:0] model_q [$];
    logic [N*DW-1:0] late_q  [$];

    sa_a_skew_feeder #(.N(N), .DW(DW), .DEPTH(DEPTH)) dut (
        .Clock          (Clock),
        .rst_n          (rst_n),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .start          (start),
        .cfg_len        (cfg_len),
        .a_out          (a_out),
        .en_shift_right (en_shift_right),
        .data_clear     (data_clear),
        .busy           (busy),
        .done           (done),
        .fifo_count     (fifo_count)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    function automatic logic [N*DW-1:0] make_vec(input int k);
        logic [N*DW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            v[i*DW +: DW] = DW'(16 * k + i);
        end
        return v;
    endfunction

    function automatic logic [N*DW-1:0] rand_vec();
        logic [N*DW-1:0] v;
        for (int i = 0; i < N; i++) begin
            v[i*DW +: DW] = DW'($urandom);
        end
        return v;
    endfunction

    // Skew rule: after advance m, lane i carries lane i of burst vector m-i.
    function automatic logic [N*DW-1:0] exp_aout(input int m, input int len);
        logic [N*DW-1:0] v;
        int idx;
        v = '0;
        for (int i = 0; i < N; i++) begin
            idx = m - i;
            if (idx >= 0 && idx < len) begin
                v[i*DW +: DW] = model_q[idx][i*DW +: DW];
            end
        end
        return v;
    endfunction

    task automatic push_vec(input logic [N*DW-1:0] v);
        s_valid = 1'b1;
        s_data  = v;
        if (s_ready) begin
            model_q.push_back(v);
        end
        tick();
        s_valid = 1'b0;
    endtask

    // Starts a burst and checks it to completion. The caller provides these controls:
    //   late_gap    - once the burst is starved for this many cycles, late_q is pushed;
    //   restart_at  - a start pulse is issued at this cycle index, mid-burst;
    //   abort_after - rst_n is pulled low once this many advances have been seen.
    task automatic run_burst(input string name, input int len, input int late_gap,
                             input int restart_at, input int abort_after,
                             output int max_stall);
        int adv, cyc, stall, pushed, clears, init_cnt, exp_cnt;
        bit done_seen;
        logic [N*DW-1:0] last_a;
        adv = 0; cyc = 0; stall = 0; pushed = 0; clears = 0; done_seen = 0;
        max_stall = 0;
        init_cnt = model_q.size();
        last_a = a_out;
        start = 1'b1;
        cfg_len = CW'(len);
        tick();
        start = 1'b0;
        while (!done_seen && cyc < 200) begin
            if (en_shift_right) begin
                adv++;
                check({name, "_a_out"}, a_out, exp_aout(adv - 1, len));
                check({name, "_busy"}, busy, done ? 1'b0 : 1'b1);
                stall = 0;
            end else if (adv > 0) begin
                check({name, "_hold"}, a_out, last_a);
                stall++;
                if (stall > max_stall) max_stall = stall;
            end
            if (data_clear) begin
                clears++;
                check({name, "_clear_no_en"}, en_shift_right, 1'b0);
            end
            exp_cnt = init_cnt + pushed - ((adv < len) ? adv : len);
            check({name, "_count"}, fifo_count, exp_cnt);
            check({name, "_ready"}, s_ready, (exp_cnt < DEPTH) ? 1'b1 : 1'b0);
            last_a = a_out;
            if (done) begin
                done_seen = 1;
                check({name, "_done_adv"}, adv, len + N - 1);
                check({name, "_done_clears"}, clears, 1);
                check({name, "_done_idle"}, busy, 1'b0);
            end
            if (abort_after > 0 && adv == abort_after) begin
                rst_n = 1'b0;
                return;
            end
            s_valid = 1'b0;
            if (pushed < late_q.size() && max_stall >= late_gap && s_ready) begin
                s_valid = 1'b1;
                s_data  = late_q[pushed];
                model_q.push_back(late_q[pushed]);
                pushed++;
            end
            start = (cyc == restart_at);
            cfg_len = (cyc == restart_at) ? CW'(2) : CW'(len);
            if (!done_seen) begin
                tick();
                cyc++;
            end
        end
        s_valid = 1'b0;
        start = 1'b0;
        check({name, "_finished"}, done_seen, 1'b1);
        for (int i = 0; i < len && model_q.size() > 0; i++) begin
            void'(model_q.pop_front());
        end
        late_q.delete();
        tick();
        check({name, "_done_single"}, done, 1'b0);
        check({name, "_idle_after"}, busy, 1'b0);
    endtask

    initial begin
        int st;
        int len;
        rst_n = 1'b0;
        s_valid = 1'b1;
        s_data = rand_vec();
        start = 1'b0;
        cfg_len = '0;

        // Reset, with s_valid held high
        repeat (3) tick();
        check("rst_a_out", a_out, '0);
        check("rst_ready", s_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_count", fifo_count, '0);
        check("rst_en", en_shift_right, 1'b0);
        check("rst_clear", data_clear, 1'b0);
        check("rst_done", done, 1'b0);
        s_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        check("rel_ready", s_ready, 1'b1);
        check("rel_count", fifo_count, '0);

        // Four known vectors, burst length 4
        for (int k = 0; k < 4; k++) push_vec(make_vec(k));
        check("t2_count", fifo_count, 4);
        run_burst("t2", 4, 0, -1, 0, st);

        // Starved burst; the remaining vectors arrive after a gap
        push_vec(make_vec(0));
        push_vec(make_vec(1));
        late_q.push_back(make_vec(2));
        late_q.push_back(make_vec(3));
        run_burst("t3", 4, 5, -1, 0, st);
        check("t3_stalled", (st >= 5) ? 1'b1 : 1'b0, 1'b1);

        // Full FIFO, then a maximum-length burst
        for (int k = 0; k < DEPTH; k++) push_vec(rand_vec());
        check("t4_full_ready", s_ready, 1'b0);
        check("t4_full_count", fifo_count, DEPTH);
        push_vec(rand_vec());
        check("t4_ninth_count", fifo_count, DEPTH);
        check("t4_model_size", model_q.size(), DEPTH);
        run_burst("t4", DEPTH, 0, -1, 0, st);

        // Starts that must be ignored
        for (int k = 0; k < 3; k++) push_vec(rand_vec());
        start = 1'b1; cfg_len = 0;
        tick();
        start = 1'b0;
        check("t5_len0_busy", busy, 1'b0);
        check("t5_len0_count", fifo_count, 3);
        tick();
        check("t5_len0_clear", data_clear, 1'b0);
        start = 1'b1; cfg_len = 9;
        tick();
        start = 1'b0;
        check("t5_len9_busy", busy, 1'b0);
        check("t5_len9_count", fifo_count, 3);
        run_burst("t5", 3, 0, 4, 0, st);
        repeat (2) tick();
        check("t5_no_restart", busy, 1'b0);
        check("t5_drained", fifo_count, 0);

        // Reset asserted in the middle of a burst
        for (int k = 0; k < 4; k++) push_vec(make_vec(k));
        run_burst("t6", 4, 0, -1, 2, st);
        #1;
        check("t6_a_out", a_out, '0);
        check("t6_en", en_shift_right, 1'b0);
        check("t6_clear", data_clear, 1'b0);
        check("t6_busy", busy, 1'b0);
        check("t6_count", fifo_count, '0);
        check("t6_done", done, 1'b0);
        repeat (3) tick();
        check("t6_done_hold", done, 1'b0);
        model_q.delete();
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) push_vec(make_vec(k));
        run_burst("t6b", 4, 0, -1, 0, st);

        // Random lengths and data; leftover vectors carry into the next burst
        for (int r = 0; r < 4; r++) begin
            len = $urandom_range(1, DEPTH);
            while (model_q.size() < len) begin
                push_vec(rand_vec());
                if ($urandom_range(0, 1) == 1) tick();
            end
            if (model_q.size() < DEPTH && $urandom_range(0, 1) == 1) push_vec(rand_vec());
            run_burst("rnd", len, 0, -1, 0, st);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
